// File: rtl/mul_issue_ctrl_pkg.sv
// Shared opcode, state and constant definitions for the multiplier issue controller.
package mul_issue_ctrl_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned ProdW = 64;

  typedef enum logic [2:0] {
    MULOP_NONE  = 3'd0,
    MULOP_MULT  = 3'd1,
    MULOP_MULTU = 3'd2,
    MULOP_MUL   = 3'd3,
    MULOP_MADD  = 3'd4,
    MULOP_MADDU = 3'd5,
    MULOP_MSUB  = 3'd6,
    MULOP_MSUBU = 3'd7
  } mul_op_e;

  typedef enum logic [1:0] {
    MUL_ST_IDLE  = 2'd0,
    MUL_ST_BUSY  = 2'd1,
    MUL_ST_DONE  = 2'd2,
    MUL_ST_DRAIN = 2'd3
  } mul_state_e;

  localparam logic             MulStart       = 1'b1;
  localparam logic             MulStop        = 1'b0;
  localparam logic             MulResultReady = 1'b1;
  localparam logic [WordW-1:0] ZeroWord       = '0;

  // Signed multiply for the two's-complement flavours of each opcode.
  function automatic logic is_signed_op(input mul_op_e op);
    return (op == MULOP_MULT) || (op == MULOP_MUL) ||
           (op == MULOP_MADD) || (op == MULOP_MSUB);
  endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// EX-stage issue/writeback controller for the iterative 32x32 multiplier.
// Issues operands, stalls while the multiplier runs, then writes HI/LO or a GPR.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [2:0]       mul_op_i,
  input  logic [WordW-1:0] rs_data_i,
  input  logic [WordW-1:0] rt_data_i,
  input  logic [WordW-1:0] hi_i,
  input  logic [WordW-1:0] lo_i,
  input  logic             flush_i,
  input  logic [ProdW-1:0] mul_result_i,
  input  logic             mul_ready_i,
  output logic             mul_start_o,
  output logic             mul_annul_o,
  output logic             mul_signed_o,
  output logic [WordW-1:0] mul_op1_o,
  output logic [WordW-1:0] mul_op2_o,
  output logic             stall_req_o,
  output logic             whilo_o,
  output logic [WordW-1:0] hi_o,
  output logic [WordW-1:0] lo_o,
  output logic             wreg_o,
  output logic [WordW-1:0] wdata_o
);

  mul_state_e       state_q, state_d;
  mul_op_e          op_q, op_d;
  logic             start_q, start_d;
  logic             annul_q, annul_d;
  logic             signed_q, signed_d;
  logic [WordW-1:0] op1_q, op1_d;
  logic [WordW-1:0] op2_q, op2_d;
  logic             whilo_q, whilo_d;
  logic [WordW-1:0] hi_q, hi_d;
  logic [WordW-1:0] lo_q, lo_d;
  logic             wreg_q, wreg_d;
  logic [WordW-1:0] wdata_q, wdata_d;

  mul_op_e          op_in;
  logic             is_mul_op;
  logic [ProdW-1:0] acc;
  logic [ProdW-1:0] acc_add;
  logic [ProdW-1:0] acc_sub;

  assign op_in     = mul_op_e'(mul_op_i);
  assign is_mul_op = op_valid_i && (op_in != MULOP_NONE);
  assign acc       = {hi_i, lo_i};
  assign acc_add   = acc + mul_result_i;
  assign acc_sub   = acc - mul_result_i;

  // Stall drops only in DONE so the pipeline advances once per mul op.
  assign stall_req_o = (state_q == MUL_ST_BUSY) ||
                       (is_mul_op && ((state_q == MUL_ST_IDLE) || (state_q == MUL_ST_DRAIN)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_ST_IDLE;
      op_q     <= MULOP_NONE;
      start_q  <= MulStop;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= ZeroWord;
      op2_q    <= ZeroWord;
      whilo_q  <= 1'b0;
      hi_q     <= ZeroWord;
      lo_q     <= ZeroWord;
      wreg_q   <= 1'b0;
      wdata_q  <= ZeroWord;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      whilo_q  <= whilo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    start_d  = start_q;
    annul_d  = 1'b0;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    whilo_d  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    wreg_d   = 1'b0;
    wdata_d  = wdata_q;

    if (flush_i) begin
      start_d = MulStop;
      annul_d = 1'b1;
      state_d = (state_q == MUL_ST_IDLE) ? MUL_ST_IDLE : MUL_ST_DRAIN;
    end else begin
      unique case (state_q)
        MUL_ST_IDLE: begin
          if (is_mul_op) begin
            op_d     = op_in;
            op1_d    = rs_data_i;
            op2_d    = rt_data_i;
            start_d  = MulStart;
            signed_d = is_signed_op(op_in);
            state_d  = MUL_ST_BUSY;
          end
        end
        MUL_ST_BUSY: begin
          // Writeback registers load on the ready edge so they are visible in DONE.
          if (mul_ready_i == MulResultReady) begin
            start_d = MulStop;
            state_d = MUL_ST_DONE;
            unique case (op_q)
              MULOP_MULT, MULOP_MULTU: begin
                {hi_d, lo_d} = mul_result_i;
                whilo_d      = 1'b1;
              end
              MULOP_MADD, MULOP_MADDU: begin
                {hi_d, lo_d} = acc_add;
                whilo_d      = 1'b1;
              end
              MULOP_MSUB, MULOP_MSUBU: begin
                {hi_d, lo_d} = acc_sub;
                whilo_d      = 1'b1;
              end
              MULOP_MUL: begin
                wdata_d = mul_result_i[WordW-1:0];
                wreg_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL_ST_DONE: begin
          state_d = MUL_ST_DRAIN;
        end
        MUL_ST_DRAIN: begin
          // Multiplier must drop ready before it may be restarted.
          if (mul_ready_i != MulResultReady) begin
            state_d = MUL_ST_IDLE;
          end
        end
        default: state_d = MUL_ST_IDLE;
      endcase
    end
  end

  assign mul_start_o  = start_q;
  assign mul_annul_o  = annul_q;
  assign mul_signed_o = signed_q;
  assign mul_op1_o    = op1_q;
  assign mul_op2_o    = op2_q;
  assign whilo_o      = whilo_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign wreg_o       = wreg_q;
  assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural iterative multiplier.
module tb_mul_issue_ctrl;

  typedef struct packed {
    logic        is_gpr;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  mul_op;
  logic [31:0] rs_data, rt_data, hi_in, lo_in;
  logic        flush;
  logic [63:0] m_res;
  logic        m_ready;
  logic        mul_start, mul_annul, mul_signed;
  logic [31:0] mul_op1, mul_op2;
  logic        stall_req, whilo, wreg;
  logic [31:0] hi_out, lo_out, wdata_out;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  mul_issue_ctrl dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid), .mul_op_i(mul_op),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .hi_i(hi_in), .lo_i(lo_in),
    .flush_i(flush), .mul_result_i(m_res), .mul_ready_i(m_ready),
    .mul_start_o(mul_start), .mul_annul_o(mul_annul), .mul_signed_o(mul_signed),
    .mul_op1_o(mul_op1), .mul_op2_o(mul_op2), .stall_req_o(stall_req),
    .whilo_o(whilo), .hi_o(hi_out), .lo_o(lo_out), .wreg_o(wreg), .wdata_o(wdata_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic op_sgn(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
  endfunction

  function automatic logic [63:0] prod64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [63:0] acc);
    exp_t e;
    logic [63:0] p, r;
    p = prod64(a, b, op_sgn(op));
    case (op)
      3'd4, 3'd5: r = acc + p;
      3'd6, 3'd7: r = acc - p;
      default:    r = p;
    endcase
    e.is_gpr = (op == 3'd3);
    e.sgn    = op_sgn(op);
    e.a      = a;
    e.b      = b;
    e.hi     = r[63:32];
    e.lo     = r[31:0];
    e.wdata  = p[31:0];
    return e;
  endfunction

  function automatic exp_t lit_exp(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi,
                                   input logic [31:0] lo, input logic [31:0] wd);
    exp_t e;
    e.is_gpr = (op == 3'd3);
    e.sgn    = op_sgn(op);
    e.a      = a;
    e.b      = b;
    e.hi     = hi;
    e.lo     = lo;
    e.wdata  = wd;
    return e;
  endfunction

  // Behavioural multiplier: latency mul_lat+1 edges after start, ready held until start drops.
  int unsigned mul_lat = 3;
  logic        m_busy;
  int unsigned m_cnt;
  logic [31:0] m_a, m_b;
  logic        m_sgn;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_cnt   <= 0;
      m_res   <= 64'd0;
    end else if (mul_annul) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_res   <= prod64(m_a, m_b, m_sgn);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_ready) begin
      if (!mul_start) m_ready <= 1'b0;
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= mul_lat;
      m_a    <= mul_op1;
      m_b    <= mul_op2;
      m_sgn  <= mul_signed;
    end
  end

  int   cyc = 0;
  int   ready_rise_cyc = 0;
  logic ready_prev = 1'b0, start_prev = 1'b0, whilo_prev = 1'b0, wreg_prev = 1'b0;

  // Output monitor: issue legality, pulse timing and writeback values.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (m_ready && !ready_prev) ready_rise_cyc <= cyc;
      if (mul_start && !start_prev) begin
        check("start_while_ready", 64'(m_ready), 64'd0);
        if (sb.size() > 0) begin
          check("issue_signed", 64'(mul_signed), 64'(sb[0].sgn));
          check("issue_op1", 64'(mul_op1), 64'(sb[0].a));
          check("issue_op2", 64'(mul_op2), 64'(sb[0].b));
        end
      end
      if (whilo) check("whilo_width", 64'(whilo_prev), 64'd0);
      if (wreg)  check("wreg_width", 64'(wreg_prev), 64'd0);
      if ((whilo && !whilo_prev) || (wreg && !wreg_prev)) begin
        check("wb_latency", 64'(cyc), 64'(ready_rise_cyc + 1));
        if (sb.size() == 0) begin
          check("unexpected_wb", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_gpr) begin
            check("mul_wreg", 64'(wreg), 64'd1);
            check("mul_whilo", 64'(whilo), 64'd0);
            check("mul_wdata", 64'(wdata_out), 64'(e.wdata));
          end else begin
            check("hilo_whilo", 64'(whilo), 64'd1);
            check("hilo_wreg", 64'(wreg), 64'd0);
            check("hilo_val", {hi_out, lo_out}, {e.hi, e.lo});
          end
        end
      end
    end
    ready_prev <= m_ready;
    start_prev <= mul_start;
    whilo_prev <= whilo;
    wreg_prev  <= wreg;
  end

  // Drive one op, hold it until the stall drops, return just after the advancing edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    int n;
    sb.push_back(e);
    op_valid = 1'b1;
    mul_op   = op;
    rs_data  = a;
    rt_data  = b;
    #1;
    check("stall_at_issue", 64'(stall_req), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_req && n < 200);
    if (n >= 200) check("issue_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    mul_op   = 3'd0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 64'(mul_start), 64'd0);
    check({tag, "_annul"}, 64'(mul_annul), 64'd0);
    check({tag, "_signed"}, 64'(mul_signed), 64'd0);
    check({tag, "_ops"}, {mul_op1, mul_op2}, 64'd0);
    check({tag, "_whilo"}, 64'(whilo), 64'd0);
    check({tag, "_hilo"}, {hi_out, lo_out}, 64'd0);
    check({tag, "_wreg"}, 64'(wreg), 64'd0);
    check({tag, "_wdata"}, 64'(wdata_out), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; mul_op = 3'd0; rs_data = '0; rt_data = '0;
    hi_in = '0; lo_in = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    idle(2);

    issue(3'd1, 32'd3, 32'hFFFFFFFB, lit_exp(3'd1, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'd0));
    idle(3);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
          lit_exp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'd0));
    idle(2);
    hi_in = 32'h00000001; lo_in = 32'h00000000;
    issue(3'd4, 32'd2, 32'd3, lit_exp(3'd4, 32'd2, 32'd3, 32'h00000001, 32'h00000006, 32'd0));
    idle(2);
    hi_in = 32'd0; lo_in = 32'd0;
    issue(3'd7, 32'd1, 32'd1, lit_exp(3'd7, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0));
    idle(2);
    mul_lat = 1;
    issue(3'd3, 32'd7, 32'hFFFFFFFE, lit_exp(3'd3, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFF2));

    // Back-to-back: MADD follows immediately, accumulating onto the MULT result.
    hi_in = 32'd0; lo_in = 32'd0;
    issue(3'd1, 32'd3, 32'hFFFFFFFB, lit_exp(3'd1, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'd0));
    hi_in = 32'hFFFFFFFF; lo_in = 32'hFFFFFFF1;
    issue(3'd4, 32'd2, 32'd3, lit_exp(3'd4, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFF7, 32'd0));
    idle(2);

    op_valid = 1'b1; mul_op = 3'd0;
    #1;
    check("none_stall", 64'(stall_req), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("none_start", 64'(mul_start), 64'd0);
    idle(1);

    // Flush mid-BUSY: annul pulse, no writeback.
    mul_lat = 4;
    op_valid = 1'b1; mul_op = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
    repeat (3) @(negedge clk);
    flush = 1'b1; op_valid = 1'b0; mul_op = 3'd0;
    @(posedge clk);
    #1;
    check("flush_annul", 64'(mul_annul), 64'd1);
    check("flush_start", 64'(mul_start), 64'd0);
    flush = 1'b0;
    @(posedge clk);
    #1;
    check("flush_annul_clear", 64'(mul_annul), 64'd0);
    idle(4);
    hi_in = 32'd0; lo_in = 32'd0;
    issue(3'd1, 32'd4, 32'd4, lit_exp(3'd1, 32'd4, 32'd4, 32'h00000000, 32'h00000010, 32'd0));
    idle(2);

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 7));
      a = $urandom;
      b = $urandom;
      hi_in = $urandom;
      lo_in = $urandom;
      mul_lat = $urandom_range(0, 5);
      issue(op, a, b, mk_exp(op, a, b, {hi_in, lo_in}));
      if (i % 2 == 0) idle(1);
    end
    idle(3);

    // Reset mid-BUSY abandons the op with everything cleared.
    mul_lat = 4;
    op_valid = 1'b1; mul_op = 3'd3; rs_data = 32'd5; rt_data = 32'd6;
    repeat (3) @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; mul_op = 3'd0;
    @(posedge clk);
    #1;
    check_all_zero("rst_busy");
    rst = 1'b0;
    idle(10);
    check("rst_busy_stall", 64'(stall_req), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
